// File: rtl/life_pkg.sv
// Shared encodings for the Game-of-Life engine: external mode inputs,
// internal sequencer states and the survive/birth thresholds.
package life_pkg;

  // Mode encodings driven by the button/mode controller
  typedef enum logic [1:0] {
    MODE_IDLE    = 2'b00,
    MODE_PROGRAM = 2'b01,
    MODE_RUN     = 2'b10,
    MODE_PAUSE   = 2'b11
  } mode_e;

  // Sequencer states; S_CALC and S_COMMIT exist only inside RUN
  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG,
    S_READY,
    S_CALC,
    S_COMMIT
  } fsm_e;

  // Live cell survives with S_MIN..S_MAX neighbours; dead cell is born with B
  localparam int unsigned S_MIN = 2;
  localparam int unsigned S_MAX = 3;
  localparam int unsigned B     = 3;

endpackage

// File: rtl/life_row_eval.sv
// Combinational next-state evaluation of one grid row from the row above,
// the row itself and the row below. Column edges are either dead or wrapped.
module life_row_eval
  import life_pkg::*;
#(
  parameter int COLS = 7,
  parameter bit WRAP = 1'b0
) (
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] cur,
  input  logic [COLS-1:0] below,
  output logic [COLS-1:0] next_row
);

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    // Column neighbour indices; the edge columns either wrap or see dead cells
    localparam int  LI    = (gi == 0) ? COLS - 1 : gi - 1;
    localparam int  RI    = (gi == COLS - 1) ? 0 : gi + 1;
    localparam bit  HAS_L = (gi != 0) || WRAP;
    localparam bit  HAS_R = (gi != COLS - 1) || WRAP;

    logic       l_a, l_c, l_b, r_a, r_c, r_b;
    logic [3:0] cnt;

    assign l_a = HAS_L ? above[LI] : 1'b0;
    assign l_c = HAS_L ? cur[LI]   : 1'b0;
    assign l_b = HAS_L ? below[LI] : 1'b0;
    assign r_a = HAS_R ? above[RI] : 1'b0;
    assign r_c = HAS_R ? cur[RI]   : 1'b0;
    assign r_b = HAS_R ? below[RI] : 1'b0;

    // Eight-neighbour population, 0..8
    assign cnt = {3'b000, l_a} + {3'b000, above[gi]} + {3'b000, r_a}
               + {3'b000, l_c}                       + {3'b000, r_c}
               + {3'b000, l_b} + {3'b000, below[gi]} + {3'b000, r_b};

    assign next_row[gi] = cur[gi] ? ((cnt >= 4'(S_MIN)) && (cnt <= 4'(S_MAX)))
                                  : (cnt == 4'(B));
  end

endmodule

// File: rtl/life_engine_param.sv
// Parametrised Game-of-Life engine: serial programming from two buttons,
// row-sequential generation sweep into a shadow buffer, single-cycle commit.
module life_engine_param
  import life_pkg::*;
#(
  parameter int ROWS  = 7,
  parameter int COLS  = 7,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic                         clka,
  input  logic                         stop,
  input  logic [1:0]                   state,
  input  logic                         btn0,
  input  logic                         btn1,
  input  logic                         step,
  input  logic                         auto_run,
  output logic [ROWS*COLS-1:0]         grid,
  output logic [$clog2(ROWS*COLS)-1:0] prog_idx,
  output logic                         busy,
  output logic                         gen_done,
  output logic [GEN_W-1:0]             gen_count,
  output logic                         stable,
  output logic                         extinct
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(ROWS);

  mode_e             mode;
  fsm_e              fsm_q, fsm_d;
  logic [RW-1:0]     row_q, row_d;
  logic [N-1:0]      grid_q, grid_d;
  logic [N-1:0]      next_q, next_d;
  logic [IW-1:0]     prog_idx_q, prog_idx_d;
  logic [GEN_W-1:0]  gen_count_q, gen_count_d;
  logic              stable_q, stable_d;
  logic              extinct_q, extinct_d;
  logic [COLS-1:0]   row_above, row_cur, row_below, row_new;

  assign mode = mode_e'(state);

  // Select the current row and its vertical neighbours out of the frozen grid
  always_comb begin
    row_cur   = grid_q[int'(row_q)*COLS +: COLS];
    row_above = '0;
    row_below = '0;
    if (row_q != '0)
      row_above = grid_q[(int'(row_q)-1)*COLS +: COLS];
    else if (WRAP != 0)
      row_above = grid_q[(ROWS-1)*COLS +: COLS];
    if (int'(row_q) != ROWS - 1)
      row_below = grid_q[(int'(row_q)+1)*COLS +: COLS];
    else if (WRAP != 0)
      row_below = grid_q[0 +: COLS];
  end

  life_row_eval #(
    .COLS (COLS),
    .WRAP (WRAP != 0)
  ) u_row_eval (
    .above    (row_above),
    .cur      (row_cur),
    .below    (row_below),
    .next_row (row_new)
  );

  // Mode-driven sequencing, programming writes, sweep and commit
  always_comb begin
    fsm_d       = fsm_q;
    row_d       = row_q;
    grid_d      = grid_q;
    next_d      = next_q;
    prog_idx_d  = prog_idx_q;
    gen_count_d = gen_count_q;
    stable_d    = stable_q;
    extinct_d   = extinct_q;

    case (mode)
      MODE_IDLE: begin
        fsm_d       = S_IDLE;
        row_d       = '0;
        grid_d      = '0;
        next_d      = '0;
        prog_idx_d  = '0;
        gen_count_d = '0;
        stable_d    = 1'b0;
        extinct_d   = 1'b0;
      end
      MODE_PROGRAM: begin
        fsm_d = S_PROG;
        if (fsm_q != S_PROG) begin
          // Entry aborts any sweep and restarts the statistics
          row_d       = '0;
          next_d      = '0;
          gen_count_d = '0;
          stable_d    = 1'b0;
          extinct_d   = 1'b0;
        end
        if (btn0 ^ btn1) begin
          grid_d[prog_idx_q] = btn1;
          prog_idx_d = (prog_idx_q == IW'(N - 1)) ? '0 : prog_idx_q + 1'b1;
        end
      end
      MODE_RUN: begin
        case (fsm_q)
          S_READY: begin
            if (step || auto_run) begin
              fsm_d = S_CALC;
              row_d = '0;
            end
          end
          S_CALC: begin
            next_d[int'(row_q)*COLS +: COLS] = row_new;
            if (int'(row_q) == ROWS - 1) begin
              fsm_d = S_COMMIT;
              row_d = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
          S_COMMIT: begin
            grid_d      = next_q;
            stable_d    = (next_q == grid_q);
            extinct_d   = (next_q == '0);
            gen_count_d = (gen_count_q == '1) ? gen_count_q : gen_count_q + 1'b1;
            fsm_d       = S_READY;
          end
          default: fsm_d = S_READY;
        endcase
      end
      default: begin
        // PAUSE: everything holds
      end
    endcase
  end

  // State registers, falling-edge clocked with asynchronous clear
  always_ff @(negedge clka or posedge stop) begin
    if (stop) begin
      fsm_q       <= S_IDLE;
      row_q       <= '0;
      grid_q      <= '0;
      next_q      <= '0;
      prog_idx_q  <= '0;
      gen_count_q <= '0;
      stable_q    <= 1'b0;
      extinct_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      row_q       <= row_d;
      grid_q      <= grid_d;
      next_q      <= next_d;
      prog_idx_q  <= prog_idx_d;
      gen_count_q <= gen_count_d;
      stable_q    <= stable_d;
      extinct_q   <= extinct_d;
    end
  end

  assign grid      = grid_q;
  assign prog_idx  = prog_idx_q;
  assign busy      = (fsm_q == S_CALC) || (fsm_q == S_COMMIT);
  assign gen_done  = (fsm_q == S_COMMIT) && (mode == MODE_RUN);
  assign gen_count = gen_count_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_engine_param.sv
// Bench for life_engine_param: a bounded 7x7 instance and a toroidal 7x7
// instance with a 2-bit generation counter share one stimulus stream and are
// compared against a cell-by-cell Game-of-Life reference.
module tb_life_engine_param;
  import life_pkg::*;

  localparam int ROWS = 7;
  localparam int COLS = 7;
  localparam int N    = ROWS * COLS;

  logic         clka = 1'b0;
  logic         stop, btn0, btn1, step, auto_run;
  logic [1:0]   state;
  logic [N-1:0] grid0, grid1;
  logic [5:0]   pidx0, pidx1;
  logic         busy0, busy1, done0, done1, stab0, stab1, ext0, ext1;
  logic [15:0]  gc0;
  logic [1:0]   gc1;

  always #5 clka = ~clka;

  life_engine_param #(.ROWS(ROWS), .COLS(COLS), .WRAP(0), .GEN_W(16)) u_bounded (
    .clka(clka), .stop(stop), .state(state), .btn0(btn0), .btn1(btn1),
    .step(step), .auto_run(auto_run), .grid(grid0), .prog_idx(pidx0),
    .busy(busy0), .gen_done(done0), .gen_count(gc0), .stable(stab0), .extinct(ext0));

  life_engine_param #(.ROWS(ROWS), .COLS(COLS), .WRAP(1), .GEN_W(2)) u_torus (
    .clka(clka), .stop(stop), .state(state), .btn0(btn0), .btn1(btn1),
    .step(step), .auto_run(auto_run), .grid(grid1), .prog_idx(pidx1),
    .busy(busy1), .gen_done(done1), .gen_count(gc1), .stable(stab1), .extinct(ext1));

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: current and previous generation per instance
  logic [N-1:0] m0, m1, p0, p1;
  int           gens;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference generation computed straight from the neighbourhood rules
  function automatic logic [N-1:0] life_next(input logic [N-1:0] g, input bit wrap);
    logic [N-1:0] res;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wrap) begin
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
            end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
              continue;
            end
            n += int'(g[rr*COLS + cc]);
          end
        end
        res[r*COLS + c] = g[r*COLS + c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] cells(input int a, input int b, input int c, input int d);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clka);
  endtask

  task automatic advance();
    p0 = m0;
    p1 = m1;
    m0 = life_next(m0, 1'b0);
    m1 = life_next(m1, 1'b1);
    gens++;
  endtask

  task automatic verify(input string tag);
    check({tag, "_grid0"}, 64'(grid0), 64'(m0));
    check({tag, "_grid1"}, 64'(grid1), 64'(m1));
    check({tag, "_gc0"}, 64'(gc0), 64'(gens > 65535 ? 65535 : gens));
    check({tag, "_gc1"}, 64'(gc1), 64'(gens > 3 ? 3 : gens));
    check({tag, "_stable0"}, 64'(stab0), 64'(m0 == p0));
    check({tag, "_stable1"}, 64'(stab1), 64'(m1 == p1));
    check({tag, "_extinct0"}, 64'(ext0), 64'(m0 == '0));
    check({tag, "_extinct1"}, 64'(ext1), 64'(m1 == '0));
  endtask

  // Clear through IDLE, then write every cell in order from the buttons
  task automatic load(input string tag, input logic [N-1:0] pat);
    state = MODE_IDLE;
    cyc();
    state = MODE_PROGRAM;
    for (int i = 0; i < N; i++) begin
      btn1 = pat[i];
      btn0 = ~pat[i];
      cyc();
    end
    btn0 = 1'b0;
    btn1 = 1'b0;
    cyc();
    m0 = pat; m1 = pat; p0 = '0; p1 = '0; gens = 0;
    check({tag, "_load_grid0"}, 64'(grid0), 64'(pat));
    check({tag, "_load_grid1"}, 64'(grid1), 64'(pat));
    check({tag, "_load_idx"}, 64'(pidx0), 64'd0);
    check({tag, "_load_gc"}, 64'(gc0), 64'd0);
    $display("load %s pattern=%013h", tag, pat);
  endtask

  // One stepped generation; optionally re-request step while the sweep runs
  task automatic do_step(input string tag, input bit extra);
    int lat;
    int more;
    state = MODE_RUN;
    cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    lat = 1;
    check({tag, "_busy"}, 64'(busy0), 64'd1);
    while (!done0 && lat < 40) begin
      step = (extra && lat == 2);
      cyc();
      lat++;
    end
    step = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(ROWS + 1));
    check({tag, "_done1"}, 64'(done1), 64'd1);
    advance();
    cyc();
    check({tag, "_pulse"}, 64'(done0), 64'd0);
    check({tag, "_idle"}, 64'(busy0), 64'd0);
    verify(tag);
    if (extra) begin
      more = 0;
      for (int i = 0; i < 20; i++) begin
        cyc();
        if (done0) more++;
      end
      check({tag, "_extra_done"}, 64'(more), 64'd0);
      check({tag, "_extra_gc"}, 64'(gc0), 64'(gens));
    end
    $display("step %s gen=%0d grid0=%013h grid1=%013h", tag, gens, grid0, grid1);
  endtask

  initial begin
    logic [N-1:0] pat;
    int  last_done;
    int  pause_left;
    bit  paused_done;
    bit  paused_between;
    bit  pending;

    stop = 1'b1; state = MODE_IDLE; btn0 = 1'b0; btn1 = 1'b0;
    step = 1'b0; auto_run = 1'b0;
    m0 = '0; m1 = '0; p0 = '0; p1 = '0; gens = 0;
    repeat (3) cyc();
    check("rst_grid", 64'(grid0), 64'd0);
    check("rst_idx", 64'(pidx0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_gc", 64'(gc0), 64'd0);
    check("rst_flags", 64'({stab0, ext0}), 64'd0);
    stop = 1'b0;
    cyc();

    // All ones, one generation, then asynchronous reset clears it
    load("ones", '1);
    do_step("ones", 1'b0);
    stop = 1'b1;
    #1;
    check("stop_grid", 64'(grid0), 64'd0);
    check("stop_gc", 64'(gc0), 64'd0);
    stop = 1'b0;
    cyc();

    // Blinker oscillates with period 2
    load("blinker", cells(23, 24, 25, -1));
    do_step("blinker1", 1'b0);
    check("blinker_vert", 64'(grid0), 64'(cells(17, 24, 31, -1)));
    do_step("blinker2", 1'b0);
    check("blinker_back", 64'(grid0), 64'(cells(23, 24, 25, -1)));

    // Block is a still life
    load("block", cells(8, 9, 15, 16));
    do_step("block", 1'b0);
    check("block_stable", 64'(stab0), 64'd1);
    check("block_alive", 64'(ext0), 64'd0);

    // Blinker on the right edge: seam crossing only when wrapping
    load("seam", cells(6, 13, 20, -1));
    do_step("seam", 1'b0);
    check("seam_wrap", 64'(grid1), 64'(cells(12, 13, 7, -1)));
    check("seam_bound", 64'(grid0), 64'(cells(12, 13, -1, -1)));

    // Lone cell dies out
    load("single", cells(24, -1, -1, -1));
    do_step("single", 1'b0);
    check("single_extinct", 64'(ext0), 64'd1);
    check("single_grid", 64'(grid0), 64'd0);

    // Second step during the sweep is dropped
    load("ignore", cells(23, 24, 25, -1));
    do_step("ignore", 1'b1);

    // Random soups, several generations each (torus counter saturates)
    for (int t = 0; t < 4; t++) begin
      pat = {$urandom, $urandom} & {$urandom, $urandom};
      load($sformatf("rnd%0d", t), pat);
      for (int g = 0; g < 5; g++) do_step($sformatf("rnd%0d_%0d", t, g), 1'b0);
    end

    // Glider free-running with a pause in the middle of a sweep
    load("glider", {cells(1, 9, 14, 15), cells(16, -1, -1, -1)});
    state = MODE_RUN;
    auto_run = 1'b1;
    last_done = -1; pause_left = 0; paused_done = 1'b0;
    paused_between = 1'b0; pending = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) state = MODE_RUN;
      end else if (!paused_done && i >= 30 && busy0) begin
        state = MODE_PAUSE;
        pause_left = 5;
        paused_done = 1'b1;
        paused_between = 1'b1;
      end
      cyc();
      if (state == MODE_PAUSE) begin
        check("pause_busy", 64'(busy0), 64'd1);
        check("pause_done", 64'(done0), 64'd0);
      end
      if (pending) begin
        verify($sformatf("auto%0d", gens));
        $display("auto gen=%0d grid0=%013h grid1=%013h", gens, grid0, grid1);
        pending = 1'b0;
      end
      if (done0) begin
        if (last_done >= 0 && !paused_between)
          check("auto_period", 64'(i - last_done), 64'(ROWS + 2));
        last_done = i;
        paused_between = 1'b0;
        advance();
        pending = 1'b1;
      end
    end
    auto_run = 1'b0;
    check("auto_gens", 64'(gens >= 12), 64'd1);

    // Entering PROGRAM mid-sweep aborts it and leaves the grid alone
    pat = cells(23, 24, 25, 40);
    load("abort", pat);
    state = MODE_RUN;
    cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (3) cyc();
    state = MODE_PROGRAM;
    cyc();
    check("abort_busy", 64'(busy0), 64'd0);
    check("abort_grid", 64'(grid0), 64'(pat));
    $display("abort program grid0=%013h", grid0);

    // Asynchronous reset in the middle of a sweep
    state = MODE_RUN;
    cyc();
    cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (3) cyc();
    check("midrst_busy_before", 64'(busy0), 64'd1);
    stop = 1'b1;
    #1;
    check("midrst_grid", 64'(grid0), 64'd0);
    check("midrst_busy", 64'(busy0), 64'd0);
    $display("abort reset grid0=%013h busy=%0d", grid0, busy0);
    cyc();
    stop = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run cannot hang
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/life_engine_param.md
Name: life_engine_param

Overview:
- Parametrised successor to the team's fixed 7x7 Game-of-Life datapath.
- Holds a ROWS x COLS cell grid, loads it serially from two buttons, and computes generations with a row-sequential sweep (one row per cycle).
- Supports bounded or toroidal edges, single-step or free-run, a generation counter and still-life/extinction flags.
- Sits between the button/mode controller and the LED/display driver.

Parameters:
- ROWS, 7: grid rows, 3..32.
- COLS, 7: grid columns, 3..32.
- WRAP, 0: 0 = cells beyond the edge are dead; 1 = toroidal, indices taken modulo ROWS/COLS.
- GEN_W, 16: generation counter width.

Ports:
- clka  in  1  clock; all flops update on the falling edge.
- stop  in  1  asynchronous active-high reset.
- state  in  2  mode: 00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE.
- btn0  in  1  PROGRAM: write 0 to the current cell; single-cycle pulse, debounced upstream.
- btn1  in  1  PROGRAM: write 1 to the current cell; single-cycle pulse.
- step  in  1  RUN: single-cycle request for one generation.
- auto_run  in  1  RUN: 1 = start a new generation automatically after each commit.
- grid  out  ROWS*COLS  current generation; bit r*COLS+c is the cell at (r,c).
- prog_idx  out  clog2(ROWS*COLS)  next cell written in PROGRAM.
- busy  out  1  sweep in progress, from the start cycle through the commit cycle.
- gen_done  out  1  one-cycle pulse in the commit cycle.
- gen_count  out  GEN_W  generations committed; saturates at all-ones.
- stable  out  1  last committed generation equalled its predecessor.
- extinct  out  1  grid is all zero after the last commit.

Behaviour:
- Reset (stop=1, asynchronous): grid=0, next-grid buffer=0, prog_idx=0, row counter=0, busy=0, gen_done=0, gen_count=0, stable=0, extinct=0; FSM goes to S_IDLE. Reset mid-sweep discards all partial results.
- FSM states: S_IDLE, S_PROG, S_READY, S_CALC, S_COMMIT. State follows the `state` input, except that S_CALC and S_COMMIT are internal.
- IDLE (00): grid, buffer, prog_idx, gen_count, stable and extinct are all cleared every cycle.
- PROGRAM (01), cell writes:
  - btn1 alone: grid[prog_idx]<=1, then prog_idx+1.
  - btn0 alone: grid[prog_idx]<=0, then prog_idx+1.
  - Both asserted or neither: no action.
  - prog_idx wraps from ROWS*COLS-1 to 0.
  - Writes go directly to grid and are visible the next cycle.
- PROGRAM (01), side effects:
  - Entering PROGRAM from RUN or PAUSE aborts any sweep; the partial buffer is discarded and grid is unchanged.
  - gen_count, stable and extinct are cleared on entry.
- RUN (10), starting a sweep:
  - In S_READY, a sweep starts on step=1, or on auto_run=1. Start -> S_CALC with row=0 and busy=1.
  - step while busy is ignored; it is not queued.
- RUN (10), sweep:
  - S_CALC computes next-state row `row` into the buffer each cycle, then increments row.
  - Neighbours are read from `grid`, which is frozen during the sweep.
  - The neighbour count is 4 bits (0..8). Rules:
    - Live cell with 2 or 3 neighbours survives; otherwise it dies.
    - Dead cell with exactly 3 neighbours becomes live.
  - After row ROWS-1 -> S_COMMIT.
- RUN (10), commit:
  - S_COMMIT (1 cycle): grid<=buffer; gen_done=1; gen_count+1 (saturating); stable<=(buffer==grid); extinct<=(buffer==0); busy=0; -> S_READY.
  - Latency from step to gen_done: ROWS+1 cycles. The new grid is visible the cycle after gen_done.
  - auto_run=1 starts the next sweep in the cycle after commit, so the period is ROWS+2 cycles.
- PAUSE (11):
  - The FSM, row counter and buffer hold, and busy holds its value.
  - Returning to RUN resumes the sweep at the held row. The result is identical to an uninterrupted sweep.
- Edges:
  - WRAP=0: out-of-range neighbours count as 0.
  - WRAP=1: row -1 maps to ROWS-1, row ROWS to 0, and likewise for columns. Corners wrap diagonally.
- Non-RUN modes never start a sweep.

Decomposition:
- Package life_pkg holds:
  - mode encodings MODE_IDLE/PROGRAM/RUN/PAUSE;
  - the FSM state enum;
  - the survive/birth constants (S_MIN=2, S_MAX=3, B=3).
- Sub-module life_row_eval (combinational):
  - Inputs: three row vectors (above, current, below) of COLS bits, plus WRAP.
  - Output: the next-state row.
  - Instanced once and muxed by the row counter.

Test Plan:
- Reset/program, 7x7 WRAP=0:
  - Stimulus: stop pulse, then 49 btn1 pulses.
  - Response: grid=all ones, prog_idx=0; after reset grid=0 and gen_count=0.
- Blinker, 7x7 WRAP=0:
  - Stimulus: cells 23,24,25 set; RUN with one step.
  - Response: gen_done 8 cycles after step; grid bits 17,24,31 set, all others 0; gen_count=1.
  - A second step restores 23,24,25.
- Still life:
  - Stimulus: block at 8,9,15,16; one step.
  - Response: grid unchanged, stable=1, extinct=0.
- Toroidal wrap, WRAP=1:
  - Stimulus: vertical blinker at cells 6,13,20 on the right edge; one step.
  - Response: bits 12,13,7 set (horizontal across the column-6/column-0 seam).
  - With WRAP=0 the same pattern gives bit 13 only set?? No: gives 12,13 only, with 7 clear.
- Extinction, pause and abort:
  - Single cell 24 + step -> extinct=1, grid=0.
  - Glider auto_run with PAUSE for 5 cycles mid-sweep -> the grid sequence matches an unpaused reference model.
  - stop asserted mid-sweep -> grid=0 and busy=0 immediately.
- Step ignored while busy:
  - Stimulus: step asserted again 2 cycles after the first.
  - Response: exactly one gen_done; gen_count increments by 1.
